// File: rtl/button_event.sv
// button_event: turns a debounced active-low button level into press/release/long/repeat pulses plus a held level
// Ports: m_clock, m_reset (async, active-high); m_state (0 = pressed), m_enable (0 = suppress events, force idle);
//        m_press, m_release, m_long, m_repeat (one-cycle pulses), m_held (level while the button is held)
module button_event #(
    parameter int LONG_COUNT   = 1000,
    parameter int REPEAT_COUNT = 250,
    parameter int CNT_W        = 16
) (
    input  logic m_clock,
    input  logic m_reset,
    input  logic m_state,
    input  logic m_enable,
    output logic m_press,
    output logic m_release,
    output logic m_long,
    output logic m_repeat,
    output logic m_held
);
    typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_COUNT - 1);
    state_t state, nx_state;
    logic [CNT_W-1:0] cnt, nx_cnt;
    logic prev_q, press_edge, rel_edge;
    logic nx_press, nx_rel, nx_long, nx_rep;
    assign press_edge = !m_state && prev_q;
    assign rel_edge   = m_state && !prev_q;
    // A release edge takes priority over a terminal count in the same cycle
    always_comb begin
        nx_state = state;
        nx_cnt   = cnt;
        nx_press = 1'b0;
        nx_rel   = 1'b0;
        nx_long  = 1'b0;
        nx_rep   = 1'b0;
        if (!m_enable) begin
            nx_state = IDLE;
            nx_cnt   = '0;
        end else if (state == IDLE) begin
            if (press_edge) begin
                nx_state = PRESSED;
                nx_press = 1'b1;
                nx_cnt   = '0;
            end
        end else if (rel_edge) begin
            nx_state = IDLE;
            nx_rel   = 1'b1;
            nx_cnt   = '0;
        end else if (cnt == (state == PRESSED ? LONG_TC : REP_TC)) begin
            nx_state = REPEAT;
            nx_long  = state == PRESSED;
            nx_rep   = state == REPEAT;
            nx_cnt   = '0;
        end else begin
            nx_cnt = cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge m_clock or posedge m_reset) begin
        if (m_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prev_q    <= 1'b1;
            m_press   <= 1'b0;
            m_release <= 1'b0;
            m_long    <= 1'b0;
            m_repeat  <= 1'b0;
            m_held    <= 1'b0;
        end else begin
            state     <= nx_state;
            cnt       <= nx_cnt;
            prev_q    <= m_state;
            m_press   <= nx_press;
            m_release <= nx_rel;
            m_long    <= nx_long;
            m_repeat  <= nx_rep;
            m_held    <= nx_state != IDLE;
        end
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed plus random stimulus for button_event, checked against a timing-based reference model
module tb_button_event;
    localparam int LONG = 8;
    localparam int REP  = 3;
    logic m_clock = 1'b0;
    logic m_reset, m_state, m_enable;
    logic m_press, m_release, m_long, m_repeat, m_held;
    logic [4:0] obs, exp_vec;
    int vectors = 0;
    int miscompares = 0;
    bit act;
    logic mprev;
    int cyc, t0;
    assign obs = {m_press, m_release, m_long, m_repeat, m_held};
    always #5 m_clock = ~m_clock;
    button_event #(.LONG_COUNT(LONG), .REPEAT_COUNT(REP), .CNT_W(16)) dut (
        .m_clock(m_clock), .m_reset(m_reset), .m_state(m_state), .m_enable(m_enable),
        .m_press(m_press), .m_release(m_release), .m_long(m_long), .m_repeat(m_repeat), .m_held(m_held)
    );
    // Model: remembers when the press pulse fired and derives long/repeat timing from elapsed cycles
    task automatic model_edge();
        int age;
        exp_vec = 5'b0;
        cyc++;
        if (!m_enable) act = 1'b0;
        else if (!act) begin
            if (mprev && !m_state) begin
                act = 1'b1;
                t0 = cyc;
                exp_vec[4] = 1'b1;
            end
        end else if (!mprev && m_state) begin
            act = 1'b0;
            exp_vec[3] = 1'b1;
        end else begin
            age = cyc - t0;
            if (age == LONG) exp_vec[2] = 1'b1;
            else if (age > LONG && (age - LONG) % REP == 0) exp_vec[1] = 1'b1;
        end
        exp_vec[0] = act;
        mprev = m_state;
    endtask
    task automatic model_reset();
        act = 1'b0;
        mprev = 1'b1;
        exp_vec = 5'b0;
    endtask
    task automatic check(input string tag, input logic [4:0] e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s obs=%b exp=%b (press,release,long,repeat,held) t=%0t", tag, obs, e, $time);
        end
    endtask
    task automatic step(input string tag);
        @(posedge m_clock);
        model_edge();
        #1;
        check(tag, exp_vec);
    endtask
    task automatic drive(input logic st, input logic en, input int n, input string tag);
        m_state = st;
        m_enable = en;
        for (int i = 0; i < n; i++) step(tag);
    endtask
    initial begin
        int run;
        m_reset = 1'b1;
        m_state = 1'b1;
        m_enable = 1'b1;
        cyc = 0;
        t0 = 0;
        model_reset();
        #12;
        check("reset", 5'b0);
        m_reset = 1'b0;
        drive(1, 1, 20, "idle");
        drive(0, 1, 4, "tap");
        drive(1, 1, 3, "tap_rel");
        drive(0, 1, 21, "long_hold");
        drive(1, 1, 3, "long_rel");
        drive(0, 1, 8, "collide");
        drive(1, 1, 3, "collide_rel");
        drive(0, 1, 1, "fast_press");
        drive(1, 1, 1, "fast_rel");
        drive(0, 1, 1, "fast_press2");
        drive(1, 1, 3, "fast_rel2");
        drive(0, 1, 6, "gate_hold");
        drive(0, 0, 3, "gate_off");
        drive(0, 1, 4, "gate_reen");
        drive(1, 1, 2, "gate_rel");
        drive(0, 1, 2, "gate_press");
        drive(1, 1, 2, "gate_rel2");
        drive(0, 1, 14, "rpt_hold");
        #2;
        m_reset = 1'b1;
        model_reset();
        #1;
        check("async_rst", 5'b0);
        @(posedge m_clock);
        #1;
        check("rst_hold", 5'b0);
        #3;
        m_reset = 1'b0;
        drive(0, 1, 12, "post_rst");
        drive(1, 1, 2, "post_rst_rel");
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                m_state = ~m_state;
                run = ($urandom % 4 == 0) ? $urandom_range(1, 30) : $urandom_range(1, 4);
            end
            run--;
            m_enable = ($urandom % 12) != 0;
            step("random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
